// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the flexible synchronous FIFO.
package fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer; wraps DEPTH-1 -> 0 so non-power-of-two depths work.
module fifo_wrap_ptr #(
  parameter int DEPTH = 8,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo_flex.sv
// Synchronous FIFO with arbitrary depth, registered-read or FWFT output,
// programmable almost flags, flush and sticky overflow/underflow flags.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATAWIDTH  = 16,
  parameter int FWFT       = FIFO_MODE_REG,
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic                          err_clr,
  input  logic [DATAWIDTH-1:0]          din,
  output logic [DATAWIDTH-1:0]          dout,
  output logic                          dout_vld,
  output logic [fifo_cnt_w(DEPTH)-1:0]  count,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int CW = fifo_cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]        wptr, rptr;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d, udf_q, udf_d;
  logic                 pop_ok, push_ok, ovf_set, udf_set;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & ~flush & (~full | pop_ok);
  assign ovf_set = push & ~flush & full & ~pop_ok;
  assign udf_set = pop & ~flush & empty;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
    ovf_d = ovf_set ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    udf_d = udf_set ? 1'b1 : (err_clr ? 1'b0 : udf_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok && !RST) mem[wptr] <= din;
  end

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PW)) u_wptr (
    .clk_i(CLK), .rst_i(RST), .clr_i(flush), .inc_i(push_ok), .ptr_o(wptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PW)) u_rptr (
    .clk_i(CLK), .rst_i(RST), .clr_i(flush), .inc_i(pop_ok), .ptr_o(rptr)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head entry is shown combinationally; masked to zero when empty.
      assign dout     = empty ? '0 : mem[rptr];
      assign dout_vld = ~empty;
    end else begin : g_reg
      logic [DATAWIDTH-1:0] dout_q;
      logic                 dout_vld_q;
      always_ff @(posedge CLK) begin
        if (RST) begin
          dout_q     <= '0;
          dout_vld_q <= 1'b0;
        end else begin
          if (pop_ok) dout_q <= mem[rptr];
          dout_vld_q <= pop_ok;
        end
      end
      assign dout     = dout_q;
      assign dout_vld = dout_vld_q;
    end
  endgenerate

  assign count        = count_q;
  assign almost_full  = (count_q >= CW'(AFULL_LVL));
  assign almost_empty = (count_q <= CW'(AEMPTY_LVL));
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: doc/sync_fifo_flex.md
SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

Interface
REQ-001 Parameter DEPTH, default 8: number of entries; any integer >= 2, power of two not required.
REQ-002 Parameter DATAWIDTH, default 16: word width in bits.
REQ-003 Parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 Parameter AFULL_LVL, default DEPTH-1: almost_full threshold, range 1..DEPTH.
REQ-005 Parameter AEMPTY_LVL, default 1: almost_empty threshold, range 0..DEPTH-1.
REQ-006 CLK  in  1  sole clock; all state updates on rising edge.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 push  in  1  write request; din captured when accepted.
REQ-009 pop  in  1  read request; consumes the head entry when accepted.
REQ-010 flush  in  1  synchronous empty-the-FIFO command.
REQ-011 err_clr  in  1  clears the sticky error flags.
REQ-012 din  in  DATAWIDTH  write data.
REQ-013 dout  out  DATAWIDTH  read data.
REQ-014 dout_vld  out  1  dout holds a valid word.
REQ-015 count  out  $clog2(DEPTH+1)  current occupancy.
REQ-016 full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-017 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-018 Pop accepted (pop_ok) = pop & !empty & !flush; push accepted (push_ok) = push & !flush & (!full | pop_ok).
REQ-019 full = (count == DEPTH); empty = (count == 0); both SHALL be decoded from the registered count.
REQ-020 almost_full = (count >= AFULL_LVL); almost_empty = (count <= AEMPTY_LVL).
REQ-021 count: +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither.
REQ-022 Write and read pointers SHALL advance by one per accepted push or pop, wrapping from DEPTH-1 to 0.
REQ-023 Data SHALL leave the FIFO in strict push order.
REQ-024 Push while full with pop_ok in the same cycle SHALL be accepted; the new word is stored behind all existing entries.
REQ-025 Push while full without pop_ok SHALL be dropped and set overflow.
REQ-026 Pop while empty SHALL be ignored and set underflow, including when a push to the empty FIFO occurs in the same cycle; that push is accepted.
REQ-027 FWFT=0: on pop_ok at edge N, dout loads the head word at edge N and dout_vld is 1 for the following cycle only; otherwise dout holds its value and dout_vld is 0.
REQ-028 FWFT=1: dout presents the head entry whenever !empty; dout_vld = !empty; a word pushed into an empty FIFO appears on dout in the cycle after the push edge; pop_ok advances to the next entry.
REQ-029 flush SHALL zero the pointers and count, clear dout_vld, and override push and pop in the same cycle; it SHALL NOT change overflow, underflow, or storage contents.
REQ-030 Once set, overflow and underflow SHALL remain set until err_clr or RST; when err_clr and a new error occur in the same cycle, the new error wins.

Reset
REQ-031 RST SHALL clear the pointers, count, dout, dout_vld, overflow and underflow to 0, and SHALL override every other input.
REQ-032 Storage array contents SHALL NOT be reset.
REQ-033 RST asserted mid-operation SHALL give empty=1 and count=0 at the next edge; prior contents SHALL never be read out.

Structure
REQ-034 Package fifo_pkg SHALL hold the mode constants FIFO_MODE_REG=0 and FIFO_MODE_FWFT=1, and a function that returns the count width for a given depth.
REQ-035 One sub-module, fifo_wrap_ptr, SHALL implement the DEPTH-modulo pointer with an increment input and a clear input; it is instantiated once for the write pointer and once for the read pointer.

Verification
REQ-036 DEPTH=5, FWFT=0: push 0x0001..0x0005 then 0xDEAD -> full=1, count=5, overflow=1; five pops return 0x0001..0x0005 with dout_vld pulses, and 0xDEAD never appears.
REQ-037 DEPTH=5: stream 12 words 0x0010..0x001B with push and pop overlapped -> pointers wrap, order preserved, count never exceeds 2.
REQ-038 Full FIFO: push 0x00BB with pop in the same cycle -> count stays 5, overflow stays 0, and 0x00BB is the last word read.
REQ-039 Empty FIFO: pop alone -> underflow=1, count=0, dout unchanged; err_clr -> underflow=0 on the next cycle.
REQ-040 count=3: flush with push of 0x0077 in the same cycle -> count=0, empty=1, 0x0077 discarded; then push 0x0042 -> 0x0042 is the first word read.
REQ-041 FWFT=1: push 0x00AA into empty FIFO -> next cycle dout=0x00AA with dout_vld=1 and no pop; RST at count=3 -> next edge count=0, empty=1, dout_vld=0.
